// File: rtl/clb_pkg.sv
// Shared definitions for the serial carry-chain adder: FSM state encoding and default slice width.
package clb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int SLICE_W_DEF = 4;

endpackage : clb_pkg

// File: rtl/slice_serial_adder_carry_chain.sv
// Ripple carry chain of INPUTS propagate/generate stages, modelled on the CLB carry primitive.
module carry_chain #(
   parameter int INPUTS = 4
) (
   input  logic [INPUTS-1:0] p,
   input  logic [INPUTS-1:0] g,
   input  logic              ci,
   output logic [INPUTS-1:0] s,
   output logic              co
);

   logic [INPUTS:0] c;

   always_comb begin
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < INPUTS; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
   end

   assign s  = p ^ c[INPUTS-1:0];
   assign co = c[INPUTS];

endmodule : carry_chain

// File: rtl/slice_serial_adder.sv
// Multi-cycle adder: one SLICE_W-bit carry-chain pass per clock between valid/ready interfaces.
// Optional SUBTRACT_EN adds a sub input selecting a - b (two's complement, co=1 means no borrow).
module slice_serial_adder
   import clb_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int SLICE_W = SLICE_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
`ifdef SUBTRACT_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co
);

   localparam int NSLICES = WIDTH / SLICE_W;
   localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

   generate
      if ((WIDTH % SLICE_W) != 0 || NSLICES < 1) begin : g_bad_width
         $error("WIDTH must be a non-zero multiple of SLICE_W");
      end
   endgenerate

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               co_q, co_d;

   logic [SLICE_W-1:0] a_sl, b_sl, s_sl;
   logic               chain_co;

   // b_q already holds the inverted operand when subtracting, so the slice path is add-only.
   always_comb begin
      a_sl = a_q[idx_q*SLICE_W +: SLICE_W];
      b_sl = b_q[idx_q*SLICE_W +: SLICE_W];
   end

   carry_chain #(
      .INPUTS (SLICE_W)
   ) u_chain (
      .p  (a_sl ^ b_sl),
      .g  (a_sl & b_sl),
      .ci (carry_q),
      .s  (s_sl),
      .co (chain_co)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      co_d    = co_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = ci;
`ifdef SUBTRACT_EN
               if (sub) begin
                  b_d     = ~b;
                  carry_d = 1'b1;
               end
`endif
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            sum_d[idx_q*SLICE_W +: SLICE_W] = s_sl;
            carry_d = chain_co;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               co_d    = chain_co;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         co_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         co_q    <= co_d;
      end
   end

   // Operand registers are only meaningful after a capture, so they carry no reset.
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end

   assign in_ready  = (state_q == ST_IDLE) && !rst;
   assign out_valid = (state_q == ST_DONE);
   assign sum       = sum_q;
   assign co        = co_q;

endmodule : slice_serial_adder

// File: tb/tb_slice_serial_adder.sv
// Directed self-checking bench for slice_serial_adder (WIDTH=16, SLICE_W=4); honours SUBTRACT_EN.
module tb_slice_serial_adder;

   localparam int WIDTH = 16;
   localparam int NSL   = 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             co;

   int tests_run;
   int tests_failed;

   slice_serial_adder #(
      .WIDTH   (WIDTH),
      .SLICE_W (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ci        (ci),
`ifdef SUBTRACT_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .co        (co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Offers one operation, waits for the result and leaves the DUT sitting in DONE.
   task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tci, input logic tsub,
                        input logic [15:0] exp_sum, input logic exp_co);
      int n;
      a        = ta;
      b        = tb;
      ci       = tci;
      sub      = tsub;
      in_valid = 1'b1;
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(NSL));
      chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
      chk({tag, "_co"}, 32'(co), 32'(exp_co));
   endtask

   initial begin
      int lows;
      logic [15:0] va [3];
      logic [15:0] vb [3];
      logic        vc [3];
      logic [15:0] vs [3];
      logic        vo [3];

      tests_run    = 0;
      tests_failed = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      ci        = 1'b0;
      sub       = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_co", 32'(co), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Carry out of the low byte into slice 2
      do_op("t1", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);
      tick();
      chk("t1_back_idle", 32'(in_ready), 32'd1);

      // Carry ripples across every slice boundary
      do_op("t2a", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
      tick();
      do_op("t2b", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
      tick();

      // Backpressure in DONE with new operands offered
      out_ready = 1'b0;
      do_op("t3", 16'h1357, 16'h2468, 1'b0, 1'b0, 16'h37BF, 1'b0);
      a        = 16'hAAAA;
      b        = 16'h5555;
      ci       = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_hold_valid", 32'(out_valid), 32'd1);
         chk("t3_hold_sum", 32'(sum), 32'h37BF);
         chk("t3_hold_co", 32'(co), 32'd0);
         chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("t3_release_in_ready", 32'(in_ready), 32'd1);
      chk("t3_release_out_valid", 32'(out_valid), 32'd0);

      // Reset in the middle of RUN
      a        = 16'h1111;
      b        = 16'h2222;
      ci       = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("t4_rst_out_valid", 32'(out_valid), 32'd0);
      chk("t4_rst_sum", 32'(sum), 32'd0);
      chk("t4_rst_co", 32'(co), 32'd0);
      chk("t4_rst_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("t4_in_ready_after_rst", 32'(in_ready), 32'd1);
      do_op("t4_op", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0);
      tick();

      // Back-to-back with in_valid held high
      va[0] = 16'h0001; vb[0] = 16'h0002; vc[0] = 1'b0; vs[0] = 16'h0003; vo[0] = 1'b0;
      va[1] = 16'h8000; vb[1] = 16'h8000; vc[1] = 1'b0; vs[1] = 16'h0000; vo[1] = 1'b1;
      va[2] = 16'h0F0F; vb[2] = 16'hF0F0; vc[2] = 1'b1; vs[2] = 16'h0000; vo[2] = 1'b1;
      in_valid = 1'b1;
      sub      = 1'b0;
      for (int k = 0; k < 3; k++) begin
         a  = va[k];
         b  = vb[k];
         ci = vc[k];
         chk("t5_accept_ready", 32'(in_ready), 32'd1);
         tick();
         lows = 0;
         while (!in_ready && lows < 20) begin
            if (out_valid) begin
               chk("t5_sum", 32'(sum), 32'(vs[k]));
               chk("t5_co", 32'(co), 32'(vo[k]));
            end
            tick();
            lows++;
         end
         chk("t5_spacing", 32'(lows), 32'(NSL + 1));
      end
      in_valid = 1'b0;

`ifdef SUBTRACT_EN
      do_op("t6a", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
      tick();
      do_op("t6b", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
      tick();
      do_op("t6c", 16'h0005, 16'h0007, 1'b0, 1'b0, 16'h000C, 1'b0);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_slice_serial_adder
